// File: rtl/cpu_pkg.sv
// Shared definitions for the multicore CPU memory port: default widths and
// the state encoding of the memory readback controller.
package cpu_pkg;

    localparam int CPU_DATA_SIZE = 32;
    localparam int CPU_ADRS_SIZE = 11;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        READ,
        DRAIN,
        DONE
    } rb_state_t;

endpackage

// File: rtl/rb_fifo2.sv
// Two-entry FIFO holding {address, data} words returned by the memory.
// A push and a pop in the same cycle are allowed even when full.
module rb_fifo2 #(
    parameter int WIDTH = 43
) (
    input  logic             sys_clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_word,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] slot [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       level;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head  = slot[rd_ptr];
    assign full  = (level == 2'd2);
    assign empty = (level == 2'd0);

    // Storage, pointers and occupancy advance on push/pop.
    always_ff @(posedge sys_clk) begin
        // NOTE: the two storage slots are reset because the head feeds the
        // streamed output directly, which must read zero out of reset.
        if (!resetn) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            level   <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register here reading
            // its pre-edge value, so push and pop see a consistent level.
            if (do_push) begin
                slot[wr_ptr] <= push_word;
                wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mem_readback_ctrl.sv
// Memory readback controller: halts the cores, burst-reads COUNT words from
// BASE (address wraps) and streams {address, data} on a valid/ready port.
module mem_readback_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_SIZE   = CPU_DATA_SIZE,
    parameter int ADRS_SIZE   = CPU_ADRS_SIZE,
    parameter int HALT_CYCLES = 4
) (
    input  logic                 sys_clk,
    input  logic                 resetn,
    input  logic                 run_req,
    output logic                 cpu_en,
    input  logic                 start,
    input  logic [ADRS_SIZE-1:0] base_adrs,
    input  logic [ADRS_SIZE:0]   count,
    output logic [ADRS_SIZE-1:0] r_adrs,
    output logic                 r_en,
    input  logic [DATA_SIZE-1:0] r_data,
    output logic [DATA_SIZE-1:0] out_data,
    output logic [ADRS_SIZE-1:0] out_adrs,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int HALT_W = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
    localparam logic [HALT_W-1:0]    HALT_LAST = HALT_W'(HALT_CYCLES - 1);
    localparam logic [HALT_W-1:0]    HALT_ONE  = HALT_W'(1);
    localparam logic [ADRS_SIZE:0]   CNT_ONE   = {{ADRS_SIZE{1'b0}}, 1'b1};
    localparam logic [ADRS_SIZE-1:0] ADRS_ONE  = {{(ADRS_SIZE-1){1'b0}}, 1'b1};

    rb_state_t            state;
    logic [ADRS_SIZE:0]   cnt_q;
    logic [ADRS_SIZE:0]   issue_cnt;
    logic [ADRS_SIZE:0]   acc_cnt;
    logic [HALT_W-1:0]    halt_cnt;
    logic                 rd_vld;
    logic [ADRS_SIZE-1:0] rd_adrs;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [1:0]           fifo_level;
    logic                 pop;

    assign cpu_en     = run_req & (state == IDLE);
    assign out_valid  = ~fifo_empty;
    assign pop        = out_valid & out_ready;
    assign fifo_level = {fifo_full, ~fifo_full & ~fifo_empty};

    // Issue a read only if the word it returns is guaranteed a FIFO slot:
    // words held after this cycle's pop, plus the word arriving on r_data,
    // must leave room. Counting the pop is what allows 1 word/cycle.
    assign r_en = (state == READ) &&
                  (({1'b0, fifo_level} + {2'b00, rd_vld}) < (3'd2 + {2'b00, pop}));

    rb_fifo2 #(
        .WIDTH(ADRS_SIZE + DATA_SIZE)
    ) u_fifo (
        .sys_clk  (sys_clk),
        .resetn   (resetn),
        .push     (rd_vld),
        .push_word({rd_adrs, r_data}),
        .pop      (pop),
        .head     ({out_adrs, out_data}),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Dump sequencing FSM with its counters, read address and r_en->data tag.
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            state     <= IDLE;
            r_adrs    <= '0;
            cnt_q     <= '0;
            issue_cnt <= '0;
            acc_cnt   <= '0;
            halt_cnt  <= '0;
            rd_vld    <= 1'b0;
            rd_adrs   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_vld  <= r_en;
            rd_adrs <= r_adrs;
            done    <= 1'b0;
            if (r_en) begin
                r_adrs    <= r_adrs + ADRS_ONE;
                issue_cnt <= issue_cnt + CNT_ONE;
            end
            if (pop) begin
                acc_cnt <= acc_cnt + CNT_ONE;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        r_adrs    <= base_adrs;
                        cnt_q     <= count;
                        issue_cnt <= '0;
                        acc_cnt   <= '0;
                        halt_cnt  <= '0;
                        busy      <= 1'b1;
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= HALT;
                        end
                    end
                end
                HALT: begin
                    if (halt_cnt == HALT_LAST) begin
                        state <= READ;
                    end else begin
                        halt_cnt <= halt_cnt + HALT_ONE;
                    end
                end
                READ: begin
                    if (r_en && (issue_cnt == cnt_q - CNT_ONE)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (acc_cnt == cnt_q - CNT_ONE)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
